// File: rtl/uart_rx_framed.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_rx_framed                                                  |
// | Desc     : Framed UART receiver with a runtime divisor, optional two stop  |
// |            bits, break detection and a held-word ready/valid handoff.      |
// |            Define UART_RX_PARITY_EN to build in odd/even parity checking.  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_rx_framed #(
  parameter int DATA_BITS = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_Rx_Serial,
  input  logic [DIV_WIDTH-1:0] i_Clks_Per_Bit,
  input  logic                 i_Two_Stop,
  input  logic [1:0]           i_Parity_Mode,
  input  logic                 i_Rx_Ready,
  input  logic                 i_Clear_Err,
  output logic                 o_Rx_DV,
  output logic [DATA_BITS-1:0] o_Rx_Byte,
  output logic                 o_Frame_Err,
  output logic                 o_Parity_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  output logic                 o_Busy
);

  localparam int                   c_IDX_W    = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [c_IDX_W-1:0]   c_LAST_IDX = c_IDX_W'(DATA_BITS - 1);
  localparam logic [DIV_WIDTH-1:0] c_MIN_DIV  = DIV_WIDTH'(4);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_DATA     = 3'd2,
`ifdef UART_RX_PARITY_EN
    S_PARITY   = 3'd3,
`endif
    S_STOP1    = 3'd4,
    S_STOP2    = 3'd5,
    S_BRK_WAIT = 3'd6
  } state_t;

  state_t                 r_state;
  logic                   r_rx_meta;
  logic                   r_rx_sync;
  logic [DIV_WIDTH-1:0]   r_count;
  logic [DIV_WIDTH-1:0]   r_div;
  logic [c_IDX_W-1:0]     r_bit_idx;
  logic                   r_two_stop;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_all_zero;

  logic                   r_rx_dv;
  logic [DATA_BITS-1:0]   r_rx_byte;
  logic                   r_frame_err;
  logic                   r_break;
  logic                   r_overrun;

  logic [DIV_WIDTH-1:0]   w_div_eff;
  logic [DIV_WIDTH-1:0]   w_div_max;
  logic                   w_full;
  logic                   w_half;
  logic                   w_finish;
  logic                   w_fin_break;

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= i_Rx_Serial;
      r_rx_sync <= r_rx_meta;
    end
  end

  assign w_div_eff = (i_Clks_Per_Bit < c_MIN_DIV) ? c_MIN_DIV : i_Clks_Per_Bit;
  assign w_div_max = r_div - 1'b1;
  assign w_full    = (r_count == w_div_max);
  assign w_half    = (r_count == (w_div_max >> 1));

  // A frame ends at the stop1 sample unless a good stop1 leads into stop2.
  always_comb begin
    w_finish    = 1'b0;
    w_fin_break = 1'b0;
    if (w_full) begin
      if (r_state == S_STOP1) begin
        w_finish    = !(r_rx_sync && r_two_stop);
        w_fin_break = !r_rx_sync && r_all_zero;
      end else if (r_state == S_STOP2) begin
        w_finish = 1'b1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_en;
  logic r_par_odd;
  logic r_par_err_pend;
  logic r_parity_err;
  logic w_par_xor;

  assign w_par_xor = (^r_shift) ^ r_rx_sync;
`else
  logic w_unused_parity;

  assign w_unused_parity = ^i_Parity_Mode;
`endif

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_div      <= c_MIN_DIV;
      r_bit_idx  <= '0;
      r_two_stop <= 1'b0;
      r_shift    <= '0;
      r_all_zero <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_en       <= 1'b0;
      r_par_odd      <= 1'b0;
      r_par_err_pend <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!r_rx_sync) begin
            r_div      <= w_div_eff;
            r_two_stop <= i_Two_Stop;
            r_count    <= '0;
            r_bit_idx  <= '0;
            r_all_zero <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_par_en       <= (i_Parity_Mode == 2'b01) || (i_Parity_Mode == 2'b10);
            r_par_odd      <= (i_Parity_Mode == 2'b01);
            r_par_err_pend <= 1'b0;
`endif
            r_state    <= S_START;
          end
        end

        // Mid-start check rejects glitches shorter than half a bit.
        S_START: begin
          if (w_half) begin
            r_count <= '0;
            r_state <= r_rx_sync ? S_IDLE : S_DATA;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        S_DATA: begin
          if (w_full) begin
            r_count            <= '0;
            r_shift[r_bit_idx] <= r_rx_sync;
            if (r_rx_sync) r_all_zero <= 1'b0;
            if (r_bit_idx == c_LAST_IDX) begin
              r_bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
              r_state   <= r_par_en ? S_PARITY : S_STOP1;
`else
              r_state   <= S_STOP1;
`endif
            end else begin
              r_bit_idx <= r_bit_idx + 1'b1;
            end
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (w_full) begin
            r_count        <= '0;
            if (r_rx_sync) r_all_zero <= 1'b0;
            r_par_err_pend <= r_par_odd ? ~w_par_xor : w_par_xor;
            r_state        <= S_STOP1;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end
`endif

        S_STOP1: begin
          if (w_full) begin
            r_count <= '0;
            if (w_fin_break)   r_state <= S_BRK_WAIT;
            else if (w_finish) r_state <= S_IDLE;
            else               r_state <= S_STOP2;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        S_STOP2: begin
          if (w_full) begin
            r_count <= '0;
            r_state <= S_IDLE;
          end else begin
            r_count <= r_count + 1'b1;
          end
        end

        S_BRK_WAIT: begin
          if (r_rx_sync) r_state <= S_IDLE;
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Holding register: a finished frame loads only if the slot is free or
  // being emptied this cycle; otherwise it is dropped and flagged.
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      r_rx_dv     <= 1'b0;
      r_rx_byte   <= '0;
      r_frame_err <= 1'b0;
      r_break     <= 1'b0;
      r_overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (r_rx_dv && i_Rx_Ready) r_rx_dv <= 1'b0;
      if (i_Clear_Err)           r_overrun <= 1'b0;
      if (w_finish) begin
        if (!r_rx_dv || i_Rx_Ready) begin
          r_rx_dv     <= 1'b1;
          r_rx_byte   <= r_shift;
          r_frame_err <= !r_rx_sync;
          r_break     <= w_fin_break;
`ifdef UART_RX_PARITY_EN
          r_parity_err <= r_par_err_pend;
`endif
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign o_Rx_DV     = r_rx_dv;
  assign o_Rx_Byte   = r_rx_byte;
  assign o_Frame_Err = r_frame_err;
  assign o_Break     = r_break;
  assign o_Overrun   = r_overrun;
  assign o_Busy      = (r_state != S_IDLE);
`ifdef UART_RX_PARITY_EN
  assign o_Parity_Err = r_parity_err;
`else
  assign o_Parity_Err = 1'b0;
`endif

endmodule
`default_nettype wire
